// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rng_pkg
//  Description : Shared types and constants for the random byte packer.
//                Holds the von Neumann extractor state encoding and the
//                default output word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package rng_pkg;

    // Default packed word width.
    localparam int RNG_WORD_W = 8;

    // Extractor state: waiting for the first bit of a pair, or holding it.
    typedef enum logic [0:0] {
        ST_EMPTY      = 1'b0,
        ST_HAVE_FIRST = 1'b1
    } vn_state_e;

endpackage : rng_pkg
`default_nettype wire

// File: rtl/vn_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : vn_extractor
//  Description : Von Neumann de-biasing extractor. Pairs consecutive valid
//                bits; pair 01 emits 0, pair 10 emits 1, 00/11 emit nothing.
//                With whiten_en low every valid bit passes straight through.
//  Ports       : clk, reset      - clock, async active-high reset
//                bit_in          - incoming random bit
//                bit_valid       - bit_in is sampled when high
//                whiten_en       - 1 = extract, 0 = raw pass-through
//                out_bit         - emitted bit (combinational)
//                out_valid       - out_bit is meaningful this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module vn_extractor
    import rng_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic whiten_en,
    output logic out_bit,
    output logic out_valid
);

    vn_state_e state_q, state_d;
    logic      first_q, first_d;

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        out_bit   = 1'b0;
        out_valid = 1'b0;

        if (!whiten_en) begin
            // Raw mode: any half-collected pair is abandoned.
            state_d   = ST_EMPTY;
            out_bit   = bit_in;
            out_valid = bit_valid;
        end else if (bit_valid) begin
            case (state_q)
                ST_EMPTY: begin
                    first_d = bit_in;
                    state_d = ST_HAVE_FIRST;
                end
                ST_HAVE_FIRST: begin
                    // Unequal pair carries one unbiased bit: the first one.
                    out_bit   = first_q;
                    out_valid = (first_q != bit_in);
                    state_d   = ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

endmodule : vn_extractor
`default_nettype wire

// File: rtl/rng_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : rng_byte_packer
//  Description : Samples a free-running random bit stream, optionally
//                de-biases it, packs bits MSB-first into WIDTH-bit words and
//                offers them on a valid/ready port. Words that complete while
//                the output register is occupied and not draining are
//                dropped and counted; the bit source is never stalled.
//  Ports       : clk, reset          - clock, async active-high reset
//                bit_in, bit_valid   - random bit and its qualifier
//                whiten_en           - enable von Neumann extraction
//                data_out[WIDTH]     - packed word
//                data_valid          - word available
//                data_ready          - consumer accepts
//                dropped             - one-cycle pulse per discarded word
//                drop_cnt[8]         - saturating discarded-word count
//  Revision    : 1.0 - initial release
// ============================================================================
module rng_byte_packer
    import rng_pkg::*;
#(
    parameter int WIDTH = RNG_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             whiten_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             dropped,
    output logic [7:0]       drop_cnt
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic             emit_bit;
    logic             emit_valid;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             dropped_q, dropped_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [WIDTH-1:0] acc_shift;
    logic             word_done;
    logic             xfer;

    vn_extractor u_vn_extractor (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .whiten_en (whiten_en),
        .out_bit   (emit_bit),
        .out_valid (emit_valid)
    );

    always_comb begin
        acc_shift = {acc_q[WIDTH-2:0], emit_bit};
        word_done = emit_valid && (bit_cnt_q == LAST_IDX);
        xfer      = data_valid_q && data_ready;

        acc_d        = acc_q;
        bit_cnt_d    = bit_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        dropped_d    = 1'b0;
        drop_cnt_d   = drop_cnt_q;

        if (xfer) begin
            data_valid_d = 1'b0;
        end

        if (emit_valid) begin
            acc_d     = acc_shift;
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        if (word_done) begin
            bit_cnt_d = '0;
            // A transfer this cycle frees the register, so the new word can
            // replace the outgoing one without a bubble.
            if (!data_valid_q || xfer) begin
                data_out_d   = acc_shift;
                data_valid_d = 1'b1;
            end else begin
                dropped_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            dropped_q    <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            dropped_q    <= dropped_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign dropped    = dropped_q;
    assign drop_cnt   = drop_cnt_q;

endmodule : rng_byte_packer
`default_nettype wire
